// File: rtl/cpu_fwd_pkg.sv
// Shared types and constants for the EX-stage operand forwarding controller.
// The stage records hold only the fields that later hazard checks need.
package cpu_fwd_pkg;

   localparam int REG_ADDR_W = 4;

   localparam logic [2:0] SEL_REGFILE = 3'b000;
   localparam logic [2:0] SEL_EXMEM   = 3'b001;
   localparam logic [2:0] SEL_MEMWB   = 3'b010;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
      logic                  load;
   } ex_rec_t;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
      logic                  load;
   } mem_rec_t;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
   } wb_rec_t;

endpackage

// File: rtl/fwd_compare.sv
// Priority compare of one EX source register against the MEM and WB records.
// The newer MEM producer wins over WB; r0 never forwards.
module fwd_compare
   import cpu_fwd_pkg::*;
(
   input  logic                  i_ex_valid,
   input  logic [REG_ADDR_W-1:0] i_src,
   input  logic                  i_mem_valid,
   input  logic [REG_ADDR_W-1:0] i_mem_rd,
   input  logic                  i_mem_we,
   input  logic                  i_mem_load,
   input  logic                  i_wb_valid,
   input  logic [REG_ADDR_W-1:0] i_wb_rd,
   input  logic                  i_wb_we,
   output logic [2:0]            o_sel
);

   logic w_src_nz;
   logic w_mem_hit;
   logic w_wb_hit;

   assign w_src_nz = |i_src;

   // A load in MEM has no ALU result yet; the stall guarantees it is caught in WB instead.
   assign w_mem_hit = i_mem_valid & i_mem_we & ~i_mem_load & (i_mem_rd == i_src);
   assign w_wb_hit  = i_wb_valid & i_wb_we & (i_wb_rd == i_src);

   always_comb begin
      o_sel = SEL_REGFILE;
      if (i_ex_valid && w_src_nz) begin
         if (w_mem_hit) begin
            o_sel = SEL_EXMEM;
         end else if (w_wb_hit) begin
            o_sel = SEL_MEMWB;
         end
      end
   end

endmodule

// File: rtl/forward_select_unit.sv
// EX/MEM/WB destination tracking, operand-select generation and load-use stall.
// Outputs are combinational from the stage flops and the decode inputs.
module forward_select_unit
   import cpu_fwd_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_we,
   input  logic                  id_is_load,
   input  logic                  flush,
   output logic [2:0]            fwd_sel_a,
   output logic [2:0]            fwd_sel_b,
   output logic                  stall
);

   ex_rec_t  r_ex;
   mem_rec_t r_mem;
   wb_rec_t  r_wb;

   logic w_stall;
   logic w_rd_hit;

   assign w_rd_hit = (r_ex.rd == id_rs1) | (r_ex.rd == id_rs2);

   // Flush dominates: the killed instruction cannot be the consumer of the load.
   assign w_stall = id_valid & r_ex.valid & r_ex.load & r_ex.we
                  & (r_ex.rd != '0) & w_rd_hit & ~flush;

   assign stall = w_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex  <= '0;
         r_mem <= '0;
         r_wb  <= '0;
      end else begin
         r_wb  <= '{valid: r_mem.valid, rd: r_mem.rd, we: r_mem.we};
         r_mem <= '{valid: r_ex.valid, rd: r_ex.rd, we: r_ex.we, load: r_ex.load};
         r_ex  <= '{valid: id_valid & ~w_stall & ~flush,
                    rs1:   id_rs1,
                    rs2:   id_rs2,
                    rd:    id_rd,
                    we:    id_we,
                    load:  id_is_load};
      end
   end

   fwd_compare u_cmp_a (
      .i_ex_valid  (r_ex.valid),
      .i_src       (r_ex.rs1),
      .i_mem_valid (r_mem.valid),
      .i_mem_rd    (r_mem.rd),
      .i_mem_we    (r_mem.we),
      .i_mem_load  (r_mem.load),
      .i_wb_valid  (r_wb.valid),
      .i_wb_rd     (r_wb.rd),
      .i_wb_we     (r_wb.we),
      .o_sel       (fwd_sel_a)
   );

   fwd_compare u_cmp_b (
      .i_ex_valid  (r_ex.valid),
      .i_src       (r_ex.rs2),
      .i_mem_valid (r_mem.valid),
      .i_mem_rd    (r_mem.rd),
      .i_mem_we    (r_mem.we),
      .i_mem_load  (r_mem.load),
      .i_wb_valid  (r_wb.valid),
      .i_wb_rd     (r_wb.rd),
      .i_wb_we     (r_wb.we),
      .o_sel       (fwd_sel_b)
   );

endmodule

// File: tb/tb_forward_select_unit.sv
// Directed instruction stream with per-cycle expected selects, stall and EX valid.
// A monitor pops expectations on the falling edge and compares.
module tb_forward_select_unit;
   import cpu_fwd_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  id_valid = 1'b0;
   logic [REG_ADDR_W-1:0] id_rs1 = '0;
   logic [REG_ADDR_W-1:0] id_rs2 = '0;
   logic [REG_ADDR_W-1:0] id_rd = '0;
   logic                  id_we = 1'b0;
   logic                  id_is_load = 1'b0;
   logic                  flush = 1'b0;
   logic [2:0]            fwd_sel_a;
   logic [2:0]            fwd_sel_b;
   logic                  stall;

   typedef struct {
      string      name;
      logic [2:0] a;
      logic [2:0] b;
      logic       st;
      logic       exv;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   forward_select_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_rd      (id_rd),
      .id_we      (id_we),
      .id_is_load (id_is_load),
      .flush      (flush),
      .fwd_sel_a  (fwd_sel_a),
      .fwd_sel_b  (fwd_sel_b),
      .stall      (stall)
   );

   task automatic chk(input string nm, input string fld, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp_v);
      end
   endtask

   // Monitor: outputs are combinational, so every driven cycle presents a result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "sel_a", int'(fwd_sel_a), int'(e.a));
            chk(e.name, "sel_b", int'(fwd_sel_b), int'(e.b));
            chk(e.name, "stall", int'(stall), int'(e.st));
            chk(e.name, "ex_valid", int'(dut.r_ex.valid), int'(e.exv));
         end
      end
   end

   task automatic drive(input logic r, input logic v, input int s1, input int s2, input int d,
                        input logic we, input logic ld, input logic fl,
                        input logic [2:0] ea, input logic [2:0] eb, input logic es,
                        input logic ev, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n      = r;
      id_valid   = v;
      id_rs1     = REG_ADDR_W'(s1);
      id_rs2     = REG_ADDR_W'(s2);
      id_rd      = REG_ADDR_W'(d);
      id_we      = we;
      id_is_load = ld;
      flush      = fl;
      e.name = nm; e.a = ea; e.b = eb; e.st = es; e.exv = ev;
      q.push_back(e);
   endtask

   task automatic nop(input logic [2:0] ea, input logic [2:0] eb, input logic ev, input string nm);
      drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, ea, eb, 1'b0, ev, nm);
   endtask

   localparam logic [2:0] RF = 3'b000;
   localparam logic [2:0] XM = 3'b001;
   localparam logic [2:0] MW = 3'b010;

   initial begin
      // r  v  rs1 rs2 rd we ld fl  sel_a sel_b stall exv
      drive(0, 0, 0, 0, 0, 0, 0, 0, RF, RF, 0, 0, "por");
      // back-to-back ALU
      drive(1, 1, 1, 2, 3, 1, 0, 0, RF, RF, 0, 0, "b2b_c0");
      drive(1, 1, 3, 5, 4, 1, 0, 0, RF, RF, 0, 1, "b2b_c1");
      nop(XM, RF, 1, "b2b_dep");
      nop(RF, RF, 0, "b2b_bubble");
      // distance two
      drive(1, 1, 1, 1, 3, 1, 0, 0, RF, RF, 0, 0, "d2_c0");
      drive(1, 1, 10, 11, 9, 1, 0, 0, RF, RF, 0, 1, "d2_c1");
      drive(1, 1, 5, 3, 6, 1, 0, 0, RF, RF, 0, 1, "d2_c2");
      nop(RF, MW, 1, "d2_dep");
      // distance three
      drive(1, 1, 1, 1, 3, 1, 0, 0, RF, RF, 0, 0, "d3_c0");
      drive(1, 1, 1, 1, 10, 1, 0, 0, RF, RF, 0, 1, "d3_c1");
      drive(1, 1, 1, 1, 11, 1, 0, 0, RF, RF, 0, 1, "d3_c2");
      drive(1, 1, 3, 3, 12, 1, 0, 0, RF, RF, 0, 1, "d3_c3");
      nop(RF, RF, 1, "d3_dep");
      // load-use
      drive(1, 1, 1, 0, 7, 1, 1, 0, RF, RF, 0, 0, "lu_load");
      drive(1, 1, 7, 7, 8, 1, 0, 0, RF, RF, 1, 1, "lu_stall");
      drive(1, 1, 7, 7, 8, 1, 0, 0, RF, RF, 0, 0, "lu_hold");
      nop(MW, MW, 1, "lu_dep");
      // MEM vs WB priority on r2
      drive(1, 1, 1, 1, 2, 1, 0, 0, RF, RF, 0, 0, "pri_c0");
      drive(1, 1, 1, 1, 2, 1, 0, 0, RF, RF, 0, 1, "pri_c1");
      drive(1, 1, 2, 2, 5, 1, 0, 0, RF, RF, 0, 1, "pri_c2");
      nop(XM, XM, 1, "pri_dep");
      // writes to r0 never forward
      drive(1, 1, 1, 1, 0, 1, 0, 0, RF, RF, 0, 0, "r0_c0");
      drive(1, 1, 1, 1, 0, 1, 0, 0, RF, RF, 0, 1, "r0_c1");
      drive(1, 1, 0, 0, 13, 1, 0, 0, RF, RF, 0, 1, "r0_c2");
      nop(RF, RF, 1, "r0_dep");
      // independent operands with different sources
      drive(1, 1, 1, 1, 4, 1, 0, 0, RF, RF, 0, 0, "mix_c0");
      drive(1, 1, 1, 1, 6, 1, 0, 0, RF, RF, 0, 1, "mix_c1");
      drive(1, 1, 6, 4, 7, 1, 0, 0, RF, RF, 0, 1, "mix_c2");
      nop(XM, MW, 1, "mix_dep");
      // flush wins over load-use stall
      drive(1, 1, 1, 0, 9, 1, 1, 0, RF, RF, 0, 0, "fl_load");
      drive(1, 1, 9, 1, 10, 1, 0, 1, RF, RF, 0, 1, "fl_flush");
      nop(RF, RF, 0, "fl_bubble");
      // reset in the middle of a stall (rs2 match)
      drive(1, 1, 1, 0, 11, 1, 1, 0, RF, RF, 0, 0, "rst_load");
      drive(1, 1, 1, 11, 12, 1, 0, 0, RF, RF, 1, 1, "rst_stall");
      drive(0, 1, 1, 11, 12, 1, 0, 0, RF, RF, 0, 0, "rst_low0");
      drive(0, 1, 1, 11, 12, 1, 0, 0, RF, RF, 0, 0, "rst_low1");
      drive(1, 1, 1, 1, 2, 1, 0, 0, RF, RF, 0, 0, "rst_rel");
      nop(RF, RF, 1, "rst_first");
      // load to r0 never stalls
      drive(1, 1, 1, 0, 0, 1, 1, 0, RF, RF, 0, 0, "ld0_load");
      drive(1, 1, 0, 0, 5, 1, 0, 0, RF, RF, 0, 1, "ld0_use");
      nop(RF, RF, 1, "ld0_dep");

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/forward_select_unit.md
# forward_select_unit

Pipeline hazard controller that generates the 3-bit operand-select codes driving the CPU core's two 3-input, 16-bit operand multiplexers, the A and B ALU operands in EX. It tracks destination registers of in-flight instructions across EX, MEM and WB, picks the forwarding source per operand, and asserts a one-cycle stall on load-use hazards. It sits between decode and execute, alongside the register file.

## Interface
- REG_ADDR_W, 4, register address width (16 architectural registers, r0 hardwired zero)
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  decode holds a real instruction
- id_rs1  in  REG_ADDR_W  decode source register A
- id_rs2  in  REG_ADDR_W  decode source register B
- id_rd  in  REG_ADDR_W  decode destination register
- id_we  in  1  decode instruction writes id_rd
- id_is_load  in  1  decode instruction is a memory load
- flush  in  1  kill the instruction entering EX (branch taken)
- fwd_sel_a  out  3  operand-A mux select for the instruction in EX
- fwd_sel_b  out  3  operand-B mux select for the instruction in EX
- stall  out  1  hold PC/IF/ID this cycle; bubble enters EX

## Operation
- Three stage records in flops: EX {valid, rs1, rs2, rd, we, load}, MEM {valid, rd, we, load}, WB {valid, rd, we}.
- Each clk edge: WB <= MEM; MEM <= EX; EX <= decode fields with valid = id_valid & ~stall & ~flush.
- Select codes: 3'b000 register file, 3'b001 EX/MEM ALU result, 3'b010 MEM/WB write-back value. Codes 3'b011–3'b111 are never driven.
- Per operand src (rs1 -> fwd_sel_a, rs2 -> fwd_sel_b), priority order:
  - EX.valid & MEM.valid & MEM.we & ~MEM.load & MEM.rd == src & src != 0 -> 001
  - else EX.valid & WB.valid & WB.we & WB.rd == src & src != 0 -> 010
  - else -> 000
- MEM-stage load match never selects 001. The stall rule guarantees the dependent has advanced to WB-match position.
- Load-use: stall = id_valid & EX.valid & EX.load & EX.we & EX.rd != 0 & (EX.rd == id_rs1 | EX.rd == id_rs2) & ~flush.
- A stall lasts exactly one cycle. Next cycle the load is in MEM, not EX, so stall drops. Upstream holds id_* stable during stall.
- Flush wins over stall. EX gets a bubble and stall is low. MEM and WB still advance.

## Timing
- Reset (rst_n low, any time): all valid bits 0 immediately, fwd_sel_a = fwd_sel_b = 000, stall = 0. Reset mid-stall clears stall in the same cycle.
- fwd_sel_* and stall are combinational from stage flops and id_* inputs. There is no register on the outputs.
- fwd_sel_* apply to the instruction occupying EX in the current cycle. A producer one instruction ahead -> 001; two ahead -> 010; three or more ahead -> 000, since the register file writes first-half/reads second-half.
- Same rd in MEM and WB: MEM (newer) wins -> 001.
- src == 0: always 000, regardless of matches.
- Both operands may forward independently in the same cycle, with different codes.
- Bubble in EX (valid 0): both selects 000.

## Structure
- Package cpu_fwd_pkg holds:
  - localparams SEL_REGFILE = 3'b000, SEL_EXMEM = 3'b001, SEL_MEMWB = 3'b010
  - packed structs ex_rec_t, mem_rec_t, wb_rec_t
- One sub-module, fwd_compare: a combinational priority compare of one source register against the MEM and WB records, producing a 3-bit select. It is instantiated twice (A, B).
- Top level holds the stage flops and the stall logic, about 150–200 lines total.

## Test plan
- Reset: drive rst_n low mid-stream with EX.load pending -> stall = 0, selects 000, all valids 0 while low. First instruction after release sees 000.
- Back-to-back ALU: r3 <= r1+r2, then r4 <= r3+r5 -> dependent in EX shows fwd_sel_a = 001, fwd_sel_b = 000.
- Distance two: r3 <= …, unrelated instruction, r6 <= r5+r3 -> fwd_sel_b = 010. Distance three -> 000.
- Load-use: load r7, then add r8 <= r7+r7 -> stall = 1 for exactly one cycle, bubble in EX. The add then shows fwd_sel_a = fwd_sel_b = 010.
- Priority and r0: writes to r2 in MEM and WB with EX reading r2 -> 001. Writes to r0 with EX reading r0 -> 000.
- Flush during load-use: flush = 1 while the stall condition holds -> stall = 0, EX valid 0 next cycle, selects 000.
